cordic_seq_ctrl: RTL
====================

CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_SHIFT_BIT, default 4: width of shift/count outputs.
REQ-002 SHALL have parameter N_ITER, default 16: CORDIC micro-rotations per operation, range 2..2^WIDTH_SHIFT_BIT.
REQ-003 SHALL have parameter SCALE_STEPS, default 4: gain-compensation add/sub steps.
REQ-004 Ports, one per line:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  start  in  1  begin operation; sampled in IDLE only.
  abort  in  1  synchronous cancel; return to IDLE.
  mode  in  1  0 = vectoring (record directions), 1 = rotation (replay directions).
  index_in  in  2  datapath lane whose sign steers vectoring.
  dp_sign  in  1  registered sign_out from the 2x4 datapath.
  ce  out  1  datapath enable.
  sel  out  1  1 = rotation step, 0 = load/add-sub step.
  shift  out  WIDTH_SHIFT_BIT  shift amount to datapath.
  count  out  WIDTH_SHIFT_BIT  current iteration k.
  sign_in  out  1  direction for current step.
  sign_rotation  out  1  equals latched mode.
  index  out  2  latched index_in.
  busy  out  1  high in every state except IDLE.
  done  out  1  one-cycle completion pulse.

Function
REQ-005 FSM states SHALL be IDLE, LOAD, SAMPLE, EXEC, WAIT, SCALE, DONE.
REQ-006 IDLE: start=1 and abort=0 latches mode, index_in; k:=0; next LOAD. start while busy SHALL be ignored.
REQ-007 LOAD (1 cycle): ce=1, sel=0, shift=0; next SAMPLE if mode=0, else EXEC.
REQ-008 SAMPLE (1 cycle): ce=0; sign_reg:=dp_sign; next EXEC.
REQ-009 EXEC: ce=1, sel=1, shift=k, count=k; sign_in=sign_reg (mode 0) or sign_mem[k] (mode 1).
REQ-010 Mode 1 EXEC: k<N_ITER-1 -> k:=k+1, stay EXEC; k=N_ITER-1 -> SCALE (macro on) or DONE.
REQ-011 Mode 0 EXEC: next WAIT. WAIT: ce=0; sign_reg:=dp_sign; sign_mem[k]:=dp_sign; then same k-increment/exit rule as REQ-010 with next state EXEC.
REQ-012 sign_mem SHALL be N_ITER bits, written only in mode 0, retained across operations until reset.
REQ-013 DONE (1 cycle): done=1, busy=0 never asserted with done... busy=1; next IDLE.
REQ-014 abort=1 in any non-IDLE state SHALL force IDLE next cycle, ce=0, no done pulse, sign_mem entries already written kept.
REQ-015 Outside EXEC/LOAD/SCALE, ce=0 and shift=0; sel=0 except EXEC.
REQ-016 Latency, start sampled cycle 0, N_ITER=16, macro off: mode 0 done at cycle 35; mode 1 done at cycle 18. Macro on: +SCALE_STEPS.
REQ-017 k counter SHALL not wrap; terminates at N_ITER-1.

Reset
REQ-018 rst_n low SHALL immediately force IDLE, k=0, sign_reg=0, sign_mem=0, latched mode=0, index=0, and all outputs 0.
REQ-019 Reset mid-operation SHALL discard the operation; no done pulse after release.

Configuration
REQ-020 Macro CORDIC_SCALE_COMP_EN defined: after last iteration enter SCALE for SCALE_STEPS cycles, ce=1, sel=0, sign_in=1, shift = 1,3,5,7 in order (truncated/padded with last value), count=step number; then DONE.
REQ-021 Macro undefined: SCALE state absent; last iteration goes directly to DONE.

Verification
REQ-022 Reset: rst_n low mid-EXEC -> next sample all outputs 0, state IDLE; release, no done.
REQ-023 Mode 0, N_ITER=16, dp_sign toggling 1,0,1,... each WAIT -> shift 0..15 on EXEC cycles, sign_in follows previous sample, done at cycle 35, sign_mem=0x5555 pattern as sampled.
REQ-024 Mode 1 after REQ-023 -> 16 consecutive EXEC cycles, sign_in = sign_mem[0..15], done at cycle 18.
REQ-025 abort asserted at k=7 in mode 0 -> IDLE next cycle, no done; sign_mem[0..6] updated, [7..15] unchanged.
REQ-026 start held high during busy and at DONE -> exactly one operation per IDLE acceptance; start+abort in IDLE -> stays IDLE.
REQ-027 CORDIC_SCALE_COMP_EN defined, mode 1 -> 4 SCALE cycles with shift 1,3,5,7, sign_in=1, done at cycle 22.

Source files
------------

// File: rtl/cordic_seq_ctrl.sv
// Sequencing controller for an iterative CORDIC datapath: vectoring records
// per-iteration directions, rotation replays them. Optional gain compensation: CORDIC_SCALE_COMP_EN.
module cordic_seq_ctrl #(
    parameter int WIDTH_SHIFT_BIT = 4,
    parameter int N_ITER          = 16,
    parameter int SCALE_STEPS     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       mode,
    input  logic [1:0]                 index_in,
    input  logic                       dp_sign,
    output logic                       ce,
    output logic                       sel,
    output logic [WIDTH_SHIFT_BIT-1:0] shift,
    output logic [WIDTH_SHIFT_BIT-1:0] count,
    output logic                       sign_in,
    output logic                       sign_rotation,
    output logic [1:0]                 index,
    output logic                       busy,
    output logic                       done
);

    if (N_ITER < 2 || N_ITER > (1 << WIDTH_SHIFT_BIT) || SCALE_STEPS < 1) begin : g_bad_cfg
        $error("cordic_seq_ctrl: N_ITER/SCALE_STEPS out of range");
    end

`ifdef CORDIC_SCALE_COMP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SAMPLE, S_EXEC, S_WAIT, S_SCALE, S_DONE
    } state_t;
    localparam logic [WIDTH_SHIFT_BIT-1:0] STEP_LAST = WIDTH_SHIFT_BIT'(SCALE_STEPS - 1);
    localparam state_t EXIT_STATE = S_SCALE;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SAMPLE, S_EXEC, S_WAIT, S_DONE
    } state_t;
    localparam state_t EXIT_STATE = S_DONE;
`endif

    localparam logic [WIDTH_SHIFT_BIT-1:0] K_LAST = WIDTH_SHIFT_BIT'(N_ITER - 1);

    state_t                     state_q, state_d;
    logic [WIDTH_SHIFT_BIT-1:0] k_q, k_d;
    logic                       sign_reg_q, sign_reg_d;
    logic [N_ITER-1:0]          sign_mem_q, sign_mem_d;
    logic                       mode_q, mode_d;
    logic [1:0]                 index_q, index_d;
    logic                       last_iter;
`ifdef CORDIC_SCALE_COMP_EN
    logic [WIDTH_SHIFT_BIT-1:0] step_q, step_d;

    // Gain-compensation shifts run 1,3,5,7 and hold at 7 beyond four steps.
    function automatic logic [WIDTH_SHIFT_BIT-1:0] scale_shift(input logic [WIDTH_SHIFT_BIT-1:0] s);
        if (s < WIDTH_SHIFT_BIT'(4))
            return WIDTH_SHIFT_BIT'(2 * int'(s) + 1);
        return WIDTH_SHIFT_BIT'(7);
    endfunction
`endif

    assign last_iter = (k_q == K_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            sign_reg_q <= 1'b0;
            // NOTE: the direction memory is only N_ITER flops and its cleared
            // state is observable through a rotation replay, so it is reset too.
            sign_mem_q <= '0;
            mode_q     <= 1'b0;
            index_q    <= '0;
`ifdef CORDIC_SCALE_COMP_EN
            step_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            sign_reg_q <= sign_reg_d;
            sign_mem_q <= sign_mem_d;
            mode_q     <= mode_d;
            index_q    <= index_d;
`ifdef CORDIC_SCALE_COMP_EN
            step_q     <= step_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every _d starts as a hold of its _q, so no path through the
        // case below can leave a variable unassigned and infer a latch.
        state_d    = state_q;
        k_d        = k_q;
        sign_reg_d = sign_reg_q;
        sign_mem_d = sign_mem_q;
        mode_d     = mode_q;
        index_d    = index_q;
`ifdef CORDIC_SCALE_COMP_EN
        step_d     = step_q;
`endif
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        mode_d  = mode;
                        index_d = index_in;
                        k_d     = '0;
`ifdef CORDIC_SCALE_COMP_EN
                        step_d  = '0;
`endif
                        state_d = S_LOAD;
                    end
                end
                S_LOAD:   state_d = mode_q ? S_EXEC : S_SAMPLE;
                S_SAMPLE: begin
                    sign_reg_d = dp_sign;
                    state_d    = S_EXEC;
                end
                S_EXEC: begin
                    if (!mode_q)        state_d = S_WAIT;
                    else if (last_iter) state_d = EXIT_STATE;
                    else                k_d     = k_q + 1'b1;
                end
                S_WAIT: begin
                    sign_reg_d      = dp_sign;
                    sign_mem_d[k_q] = dp_sign;
                    if (last_iter) begin
                        state_d = EXIT_STATE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_EXEC;
                    end
                end
`ifdef CORDIC_SCALE_COMP_EN
                S_SCALE: begin
                    if (step_q == STEP_LAST) state_d = S_DONE;
                    else                     step_d  = step_q + 1'b1;
                end
`endif
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ce            = 1'b0;
        sel           = 1'b0;
        shift         = '0;
        count         = k_q;
        sign_in       = 1'b0;
        sign_rotation = mode_q;
        index         = index_q;
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        unique case (state_q)
            S_LOAD: ce = 1'b1;
            S_EXEC: begin
                ce      = 1'b1;
                sel     = 1'b1;
                shift   = k_q;
                sign_in = mode_q ? sign_mem_q[k_q] : sign_reg_q;
            end
`ifdef CORDIC_SCALE_COMP_EN
            S_SCALE: begin
                ce      = 1'b1;
                sign_in = 1'b1;
                shift   = scale_shift(step_q);
                count   = step_q;
            end
`endif
            default: ;
        endcase
    end

endmodule
